sram_arbiter_multiport: RTL

- Time-sliced single-SRAM arbiter for the SAM Coupé core: video fetch (ASIC), Z80 CPU and an auxiliary DMA channel (disk/loader) share one asynchronous SRAM.
- Generalises the two-party turn-based arbiter: parametrised address/data width, programmable read/write strobe lengths, a third channel with a req/ack handshake, and no repeat of completed CPU accesses after pre-emption.
- Sits between the ASIC/CPU buses and the top-level SRAM pins.

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_arbiter_multiport_if.sv | 22 ++
 rtl/sram_strobe_timer.sv | 26 ++
 rtl/sram_arbiter_multiport.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding and strobe counter width for the SRAM arbiter
package sram_arb_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    S_VID   = 3'd0,
    S_IDLE  = 3'd1,
    S_CRD   = 3'd2,
    S_CWR   = 3'd3,
    S_CHOLD = 3'd4,
    S_ARD   = 3'd5,
    S_AWR   = 3'd6
  } arb_state_e;

  function automatic logic [CNT_W-1:0] strobe_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_multiport_if.sv
// rtl/sram_arbiter_multiport_if.sv - auxiliary DMA channel req/ack handshake
interface sram_arbiter_multiport_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_ack;
  logic [DW-1:0] aux_rdata;

  modport master (
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_ack, aux_rdata
  );

  modport slave (
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_ack, aux_rdata
  );
endinterface

// File: rtl/sram_strobe_timer.sv
// rtl/sram_strobe_timer.sv - loadable down-counter timing SRAM read/write strobes
module sram_strobe_timer
  import sram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_arbiter_multiport.sv
// rtl/sram_arbiter_multiport.sv - video/CPU/aux time-sliced arbiter for one async SRAM
// Build option: SRAM_RDLATCH_EN registers CPU read data instead of passing the bus through.
module sram_arbiter_multiport
  import sram_arb_pkg::*;
#(
  parameter int AW        = 19,
  parameter int DW        = 8,
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          whichturn,
  input  logic [AW-1:0] vramaddr,
  output logic [DW-1:0] data_to_asic,
  input  logic [AW-1:0] cpuramaddr,
  input  logic          mreq_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic          rfsh_n,
  input  logic [DW-1:0] data_from_cpu,
  output logic [DW-1:0] data_to_cpu,
  sram_arbiter_multiport_if.slave aux,
  output logic [AW-1:0] sram_a,
  output logic          sram_we_n,
  inout  wire  [DW-1:0] sram_d
);

  localparam logic [CNT_W-1:0] RD_LOAD = strobe_load(RD_CYCLES);
  localparam logic [CNT_W-1:0] WE_LOAD = strobe_load(WE_CYCLES);

  arb_state_e       state_q, state_d;
  logic             cpu_done_q, cpu_done_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             cpu_rd_req, cpu_wr_req, aux_go;
  logic             drive;

  sram_strobe_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign cpu_rd_req = !mreq_n && !rd_n && !cpu_done_q;
  assign cpu_wr_req = !mreq_n && rd_n && rfsh_n && !wr_n && !cpu_done_q;
  // Aux only gets the bus when the CPU is not in a real memory cycle.
  assign aux_go     = aux.aux_req && (mreq_n || !rfsh_n);

  always_comb begin
    state_d    = state_q;
    cpu_done_d = cpu_done_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    if (whichturn) begin
      state_d = S_VID;
    end else begin
      case (state_q)
        S_VID: state_d = S_IDLE;
        S_IDLE: begin
          if (cpu_rd_req) begin
            state_d  = S_CRD;
            tmr_load = 1'b1;
            tmr_val  = RD_LOAD;
          end else if (cpu_wr_req) begin
            state_d  = S_CWR;
            tmr_load = 1'b1;
            tmr_val  = WE_LOAD;
          end else if (aux_go) begin
            state_d  = aux.aux_we ? S_AWR : S_ARD;
            tmr_load = 1'b1;
            tmr_val  = aux.aux_we ? WE_LOAD : RD_LOAD;
          end
        end
        S_CRD, S_CWR: begin
          if (tmr_done) begin
            state_d    = S_CHOLD;
            cpu_done_d = 1'b1;
          end
        end
        S_ARD, S_AWR: begin
          if (tmr_done) begin
            state_d = S_IDLE;
            ack_d   = 1'b1;
            if (state_q == S_ARD) rdata_d = sram_d;
          end
        end
        S_CHOLD: if (mreq_n) state_d = S_IDLE;
        default: state_d = S_VID;
      endcase
    end
    // A withdrawn CPU cycle re-arms the CPU path, even across a video slot.
    if (mreq_n) cpu_done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_VID;
      cpu_done_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cpu_done_q <= cpu_done_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign drive     = !whichturn && (state_q == S_CWR || state_q == S_AWR);
  assign sram_we_n = !drive;
  assign sram_d    = drive ? ((state_q == S_AWR) ? aux.aux_wdata : data_from_cpu) : {DW{1'bz}};

  always_comb begin
    sram_a = cpuramaddr;
    if (whichturn) sram_a = vramaddr;
    else if (state_q == S_ARD || state_q == S_AWR) sram_a = aux.aux_addr;
  end

  assign data_to_asic  = whichturn ? sram_d : {DW{1'b1}};
  assign aux.aux_ack   = ack_q;
  assign aux.aux_rdata = rdata_q;

`ifdef SRAM_RDLATCH_EN
  logic [DW-1:0] cpu_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= {DW{1'b1}};
    end else if (!whichturn && state_q == S_CRD && tmr_done) begin
      cpu_rdata_q <= sram_d;
    end
  end

  assign data_to_cpu = cpu_rdata_q;
`else
  assign data_to_cpu = (!whichturn && (state_q == S_IDLE || state_q == S_CRD || state_q == S_CHOLD))
                       ? sram_d : {DW{1'b1}};
`endif

endmodule
